// File: rtl/genaxis_axis_rr_arbiter.sv
// rtl/genaxis_axis_rr_arbiter.sv - packet-granular round-robin AXIS arbiter with registered output
module genaxis_axis_rr_arbiter #(
    parameter int N_PORTS     = 4,
    parameter int ID_WIDTH    = 10,
    parameter int DATA_WIDTH  = 32,
    parameter int TKEEP_WIDTH = DATA_WIDTH / 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             enable_i,
    input  logic [N_PORTS-1:0]               port_mask_i,
    input  logic [N_PORTS*ID_WIDTH-1:0]      s_axis_tid_i,
    input  logic [N_PORTS*DATA_WIDTH-1:0]    s_axis_tdata_i,
    input  logic [N_PORTS*TKEEP_WIDTH-1:0]   s_axis_tkeep_i,
    input  logic [N_PORTS-1:0]               s_axis_tlast_i,
    input  logic [N_PORTS-1:0]               s_axis_tvalid_i,
    output logic [N_PORTS-1:0]               s_axis_tready_o,
    output logic [ID_WIDTH-1:0]              m_axis_tid_o,
    output logic [DATA_WIDTH-1:0]            m_axis_tdata_o,
    output logic [TKEEP_WIDTH-1:0]           m_axis_tkeep_o,
    output logic                             m_axis_tlast_o,
    output logic                             m_axis_tvalid_o,
    input  logic                             m_axis_tready_i,
    output logic [$clog2(N_PORTS)-1:0]       grant_o,
    output logic                             busy_o
);
    localparam int GW = $clog2(N_PORTS);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                 state_q, state_d;
    logic [GW-1:0]          grant_q, grant_d;
    logic [GW-1:0]          last_grant_q, last_grant_d;
    logic [ID_WIDTH-1:0]    tid_q, tid_d;
    logic [DATA_WIDTH-1:0]  tdata_q, tdata_d;
    logic [TKEEP_WIDTH-1:0] tkeep_q, tkeep_d;
    logic                   tlast_q, tlast_d;
    logic                   tvalid_q, tvalid_d;

    logic [N_PORTS-1:0]     req;
    logic                   load;
    logic                   pick_found;
    logic [GW-1:0]          pick;
    logic [GW-1:0]          idx;

    assign req  = s_axis_tvalid_i & port_mask_i;
    // Output register may take a new beat when empty or being drained this cycle.
    assign load = ~tvalid_q | m_axis_tready_i;

    // Round-robin search starting just after the last granted port; wraps at N_PORTS.
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        idx        = '0;
        for (int i = 1; i <= N_PORTS; i++) begin
            idx = GW'((int'(last_grant_q) + i) % N_PORTS);
            if (!pick_found && req[idx]) begin
                pick       = idx;
                pick_found = 1'b1;
            end
        end
    end

    // Arbitration FSM plus output register next-state; grant held until tlast transfers.
    always_comb begin
        state_d         = state_q;
        grant_d         = grant_q;
        last_grant_d    = last_grant_q;
        tid_d           = tid_q;
        tdata_d         = tdata_q;
        tkeep_d         = tkeep_q;
        tlast_d         = tlast_q;
        tvalid_d        = tvalid_q;
        s_axis_tready_o = '0;
        case (state_q)
            IDLE: begin
                if (load) begin
                    tvalid_d = 1'b0;
                end
                if (enable_i && pick_found) begin
                    grant_d = pick;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (load) begin
                    s_axis_tready_o[grant_q] = 1'b1;
                    if (s_axis_tvalid_i[grant_q]) begin
                        tid_d    = s_axis_tid_i[int'(grant_q)*ID_WIDTH +: ID_WIDTH];
                        tdata_d  = s_axis_tdata_i[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
                        tkeep_d  = s_axis_tkeep_i[int'(grant_q)*TKEEP_WIDTH +: TKEEP_WIDTH];
                        tlast_d  = s_axis_tlast_i[grant_q];
                        tvalid_d = 1'b1;
                        if (s_axis_tlast_i[grant_q]) begin
                            last_grant_d = grant_q;
                            state_d      = IDLE;
                        end
                    end else begin
                        tvalid_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset truncates any packet in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(N_PORTS - 1);
            tid_q        <= '0;
            tdata_q      <= '0;
            tkeep_q      <= '0;
            tlast_q      <= 1'b0;
            tvalid_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            tid_q        <= tid_d;
            tdata_q      <= tdata_d;
            tkeep_q      <= tkeep_d;
            tlast_q      <= tlast_d;
            tvalid_q     <= tvalid_d;
        end
    end

    assign m_axis_tid_o    = tid_q;
    assign m_axis_tdata_o  = tdata_q;
    assign m_axis_tkeep_o  = tkeep_q;
    assign m_axis_tlast_o  = tlast_q;
    assign m_axis_tvalid_o = tvalid_q;
    assign grant_o         = grant_q;
    assign busy_o          = (state_q == LOCKED);
endmodule

// File: tb/tb_genaxis_axis_rr_arbiter.sv
// tb/tb_genaxis_axis_rr_arbiter.sv - self-checking bench for genaxis_axis_rr_arbiter
module tb_genaxis_axis_rr_arbiter;
    typedef struct {
        logic [9:0]  tid;
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } beat_t;

    typedef struct {
        int         prev;
        logic [3:0] mask;
        logic [3:0] req;
        logic       en;
        logic       exp_busy;
        int         exp_grant;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic [3:0]   mask;
    logic [39:0]  tid;
    logic [127:0] data;
    logic [15:0]  keep;
    logic [3:0]   lastv;
    logic [3:0]   vld;
    logic [3:0]   s_tready;
    logic [9:0]   m_tid;
    logic [31:0]  m_data;
    logic [3:0]   m_keep;
    logic         m_last;
    logic         m_valid;
    logic         mrdy;
    logic [1:0]   grant;
    logic         busy;

    genaxis_axis_rr_arbiter dut (
        .clk(clk), .reset(reset), .enable_i(en), .port_mask_i(mask),
        .s_axis_tid_i(tid), .s_axis_tdata_i(data), .s_axis_tkeep_i(keep),
        .s_axis_tlast_i(lastv), .s_axis_tvalid_i(vld), .s_axis_tready_o(s_tready),
        .m_axis_tid_o(m_tid), .m_axis_tdata_o(m_data), .m_axis_tkeep_o(m_keep),
        .m_axis_tlast_o(m_last), .m_axis_tvalid_o(m_valid), .m_axis_tready_i(mrdy),
        .grant_o(grant), .busy_o(busy)
    );

    always #5 clk = ~clk;

    int    total = 0;
    int    bad   = 0;
    beat_t src_q[4][$];
    beat_t mdl_q[4][$];
    beat_t exp_q[$];
    int    ord_q[$];
    bit    hold[4];
    int    gap_force[4];
    bit    mid[4];
    bit    gap_rand;
    int    rdy_mode;
    int    cyc;
    int    first_fire, last_fire;
    int    trig_port, trig_kind;
    bit    trig_done;
    int    stall_chk;
    bit    prev_stall;
    beat_t prev_beat;
    vec_t  tbl[10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        en = 1'b1; mask = 4'hF; vld = '0; lastv = '0; tid = '0; data = '0; keep = '0; mrdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            src_q[k].delete(); mdl_q[k].delete();
            hold[k] = 1'b0; gap_force[k] = 0; mid[k] = 1'b0;
        end
        exp_q.delete(); ord_q.delete();
        gap_rand = 1'b0; rdy_mode = 0; cyc = 0; first_fire = -1; last_fire = -1;
        trig_kind = 0; trig_port = 0; trig_done = 1'b0; stall_chk = 0; prev_stall = 1'b0;
        @(posedge clk); @(posedge clk);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic gen_pkt(input int p, input int len, input logic [9:0] t, input logic [3:0] lkeep, input bit rnd);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.tid  = t;
            b.data = rnd ? $urandom : 32'(i);
            b.keep = (i == len - 1) ? lkeep : 4'hF;
            b.last = (i == len - 1);
            src_q[p].push_back(b);
            mdl_q[p].push_back(b);
        end
    endtask

    // Expected output stream: whole packets concatenated in the given port order.
    task automatic build_exp();
        beat_t b;
        foreach (ord_q[j]) begin
            do begin
                b = mdl_q[ord_q[j]].pop_front();
                exp_q.push_back(b);
            end while (!b.last);
        end
    endtask

    // Round-robin order over ports that still hold packets, starting after port 3.
    task automatic rr_order();
        int npk[4];
        int rem = 0;
        int lst = 3;
        for (int k = 0; k < 4; k++) begin
            npk[k] = 0;
            foreach (mdl_q[k][j]) if (mdl_q[k][j].last) npk[k]++;
            rem += npk[k];
        end
        while (rem > 0) begin
            for (int i = 1; i <= 4; i++) begin
                int p = (lst + i) % 4;
                if (npk[p] > 0) begin
                    ord_q.push_back(p); npk[p]--; rem--; lst = p;
                    break;
                end
            end
        end
    endtask

    task automatic drive_inputs();
        beat_t b;
        bit v;
        for (int k = 0; k < 4; k++) begin
            v = 1'b0;
            if (src_q[k].size() > 0) begin
                b = src_q[k][0];
                tid[k*10 +: 10] = b.tid; data[k*32 +: 32] = b.data;
                keep[k*4 +: 4] = b.keep; lastv[k] = b.last;
                v = !hold[k] && gap_force[k] == 0 && !(gap_rand && mid[k] && $urandom_range(0, 3) == 0);
            end
            if (gap_force[k] > 0) gap_force[k]--;
            vld[k] = v;
        end
        case (rdy_mode)
            1:       mrdy = ($urandom_range(0, 3) != 0);
            2:       mrdy = ~mrdy;
            default: mrdy = 1'b1;
        endcase
    endtask

    task automatic step();
        logic [3:0] ifire;
        bit         ofire;
        beat_t      cur, b;
        @(negedge clk);
        chk("tready_onehot", 64'((s_tready & (s_tready - 4'd1)) != 0), 0);
        if (stall_chk > 0) begin
            chk("stall_tready0", s_tready[0], 0);
            stall_chk--;
        end
        cur.tid = m_tid; cur.data = m_data; cur.keep = m_keep; cur.last = m_last;
        if (prev_stall)
            chk("stall_hold", {m_valid, cur.tid, cur.data, cur.keep, cur.last},
                {1'b1, prev_beat.tid, prev_beat.data, prev_beat.keep, prev_beat.last});
        ofire = m_valid & mrdy;
        prev_stall = m_valid & ~mrdy;
        prev_beat = cur;
        ifire = vld & s_tready;
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            if (ifire[k]) begin
                b = src_q[k].pop_front();
                mid[k] = !b.last;
            end
        end
        if (!trig_done && trig_kind != 0 && ifire[trig_port]) begin
            trig_done = 1'b1;
            case (trig_kind)
                1: mask[trig_port] = 1'b0;
                2: en = 1'b0;
                3: begin gap_force[3] = 5; hold[0] = 1'b0; stall_chk = 6; end
                default: ;
            endcase
        end
        if (ofire) begin
            if (first_fire < 0) first_fire = cyc;
            last_fire = cyc;
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", 1, 0);
            end else begin
                b = exp_q.pop_front();
                chk("out_beat", {cur.tid, cur.data, cur.keep, cur.last}, {b.tid, b.data, b.keep, b.last});
            end
        end
        drive_inputs();
        cyc++;
    endtask

    task automatic run_check(input int max_cyc);
        int n = 0;
        while (exp_q.size() > 0 && n < max_cyc) begin
            step(); n++;
        end
        chk("drain_left", exp_q.size(), 0);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("idle_busy", {busy, s_tready}, 0);
        end
    endtask

    initial begin
        tbl[0] = '{-1, 4'hF, 4'hF, 1'b1, 1'b1, 0};
        tbl[1] = '{-1, 4'hF, 4'b0100, 1'b1, 1'b1, 2};
        tbl[2] = '{-1, 4'b1110, 4'hF, 1'b1, 1'b1, 1};
        tbl[3] = '{0, 4'hF, 4'hF, 1'b1, 1'b1, 1};
        tbl[4] = '{1, 4'hF, 4'b0011, 1'b1, 1'b1, 0};
        tbl[5] = '{2, 4'hF, 4'b0100, 1'b1, 1'b1, 2};
        tbl[6] = '{3, 4'b0000, 4'hF, 1'b1, 1'b0, 3};
        tbl[7] = '{1, 4'hF, 4'hF, 1'b0, 1'b0, 1};
        tbl[8] = '{2, 4'b0101, 4'hF, 1'b1, 1'b1, 0};
        tbl[9] = '{0, 4'hF, 4'b1001, 1'b1, 1'b1, 3};

        // Reset state
        do_reset();
        chk("rst_outputs", {m_valid, m_last, m_data, m_tid, m_keep}, 0);
        chk("rst_ctrl", {s_tready, grant, busy}, 0);

        // Arbitration table: optional one-beat packet from prev, then one arbitration
        foreach (tbl[r]) begin
            do_reset();
            lastv = 4'hF;
            if (tbl[r].prev >= 0) begin
                vld = 4'(1 << tbl[r].prev);
                @(posedge clk); @(posedge clk); #1;
            end
            vld = tbl[r].req; mask = tbl[r].mask; en = tbl[r].en;
            @(posedge clk); #1;
            chk($sformatf("tbl%0d_busy", r), busy, tbl[r].exp_busy);
            chk($sformatf("tbl%0d_grant", r), grant, tbl[r].exp_grant);
            chk($sformatf("tbl%0d_tready", r), s_tready, tbl[r].exp_busy ? 4'(1 << tbl[r].exp_grant) : 4'h0);
        end

        // Fairness: 3-beat packets on all ports, downstream always ready
        do_reset();
        for (int p = 0; p < 4; p++) for (int j = 0; j < 2; j++) gen_pkt(p, 3, 10'(p), 4'hF, 1'b1);
        rr_order(); build_exp(); drive_inputs();
        run_check(200);
        chk("fair_span", last_fire - first_fire + 1, 31);

        // Backpressure: port 2, 8 beats tdata=i, ready toggling
        do_reset();
        rdy_mode = 2;
        gen_pkt(2, 8, 10'h2, 4'hF, 1'b0);
        ord_q = '{2}; build_exp(); drive_inputs();
        run_check(100);

        // Mask cleared while port 1 is mid-packet
        do_reset();
        for (int p = 0; p < 4; p++) for (int j = 0; j < 2; j++) gen_pkt(p, 4, 10'(p), 4'hF, 1'b1);
        trig_kind = 1; trig_port = 1;
        ord_q = '{0, 1, 2, 3, 0, 2, 3}; build_exp(); drive_inputs();
        run_check(200);

        // Enable dropped mid-packet on port 0
        do_reset();
        for (int p = 0; p < 4; p++) gen_pkt(p, 4, 10'(p), 4'hF, 1'b1);
        trig_kind = 2; trig_port = 0;
        ord_q = '{0}; build_exp(); drive_inputs();
        run_check(100);

        // Stall lock: port 3 gaps 5 cycles while port 0 requests
        do_reset();
        gen_pkt(3, 4, 10'h3, 4'hF, 1'b1);
        gen_pkt(0, 2, 10'h0, 4'hF, 1'b1);
        hold[0] = 1'b1;
        trig_kind = 3; trig_port = 3;
        ord_q = '{3, 0}; build_exp(); drive_inputs();
        run_check(100);
        chk("stall_seen", trig_done, 1);

        // Pass-through of tid and last-beat tkeep
        do_reset();
        gen_pkt(1, 3, 10'h155, 4'b0011, 1'b1);
        ord_q = '{1}; build_exp(); drive_inputs();
        run_check(100);

        // Randomized traffic against the packet-order model
        for (int rep = 0; rep < 3; rep++) begin
            do_reset();
            gap_rand = 1'b1; rdy_mode = 1;
            for (int p = 0; p < 4; p++) begin
                int np = $urandom_range(1, 5);
                for (int j = 0; j < np; j++)
                    gen_pkt(p, $urandom_range(1, 6), 10'($urandom), 4'($urandom), 1'b1);
            end
            rr_order(); build_exp(); drive_inputs();
            run_check(3000);
        end

        // Reset mid-packet on port 1
        do_reset();
        gen_pkt(1, 6, 10'h1, 4'hF, 1'b1);
        trig_kind = 4; trig_port = 1;
        drive_inputs();
        for (int n = 0; n < 20 && !trig_done; n++) step();
        chk("rst_mid_reached", trig_done, 1);
        chk("rst_pre_valid", m_valid, 1);
        #2 reset = 1'b1;
        #1;
        chk("rst_async_valid", m_valid, 0);
        chk("rst_async_tready", s_tready, 0);
        chk("rst_async_busy", busy, 0);
        do_reset();
        for (int p = 0; p < 4; p++) gen_pkt(p, 1, 10'(p), 4'hF, 1'b1);
        ord_q = '{0, 1, 2, 3}; build_exp(); drive_inputs();
        step();
        chk("rst_first_grant", {busy, grant}, {1'b1, 2'd0});
        run_check(100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
